// File: rtl/memc_dump.sv
// Sequential dump of a memc array: one entry read per beat, presented on a
// valid/ready output with index, file tag and last marker.
module memc_dump #(
    parameter int Size  = 16,
    parameter int Depth = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [4:0]      file_id,
    input  logic            abort,
    input  logic            mem_write,
    input  logic [Size-1:0] mem_rd_data,
    output logic [7:0]      mem_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_index,
    output logic [Size-1:0] out_data,
    output logic [4:0]      out_file_id,
    output logic            out_last,
    output logic            busy,
    output logic            done
);
    localparam logic [7:0] LAST = 8'(Depth - 1);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
    state_t state, nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // abort outranks out_ready, which outranks the write stall
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (start) nxt = READ;
            READ: begin
                if (abort)           nxt = IDLE;
                else if (!mem_write) nxt = HOLD;
            end
            HOLD: begin
                if (abort)          nxt = IDLE;
                else if (out_ready) nxt = (mem_addr == LAST) ? DONE : READ;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    assign out_last = out_valid && (out_index == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_file_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        out_file_id <= file_id;
                        mem_addr    <= '0;
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        mem_addr  <= '0;
                    end else if (!mem_write) begin
                        out_data  <= mem_rd_data;
                        out_index <= mem_addr;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        mem_addr  <= '0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        // address parks on the final entry; DONE clears it
                        if (mem_addr != LAST) mem_addr <= mem_addr + 8'd1;
                    end
                end
                DONE: mem_addr <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_memc_dump.sv
// Directed bench for memc_dump: a per-cycle vector table plus hand sequences
// for full dump with backpressure/stall, abort, ignored start and async reset.
module tb_memc_dump;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, mem_write, out_ready;
    logic [4:0]  file_id;
    logic [15:0] mem_rd_data;
    logic [7:0]  mem_addr, out_index;
    logic        out_valid, out_last, busy, done;
    logic [15:0] out_data;
    logic [4:0]  out_file_id;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    // memc model: combinational read, forced to zero during a write
    assign mem_rd_data = mem_write ? 16'd0 : mem[mem_addr];

    memc_dump #(.Size(16), .Depth(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .file_id(file_id),
        .abort(abort), .mem_write(mem_write), .mem_rd_data(mem_rd_data),
        .mem_addr(mem_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .out_file_id(out_file_id),
        .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic [4:0]  fid;
        logic        ab, mw, rdy;
        logic        vld;
        logic [7:0]  idx;
        logic [15:0] dat;
        logic [7:0]  addr;
        logic        bsy, dn;
        logic [4:0]  ofid;
    } vec_t;

    vec_t tbl [10];

    // advance with out_ready=1 until the beat at idx is presented (checked at negedge)
    task automatic run_to(input logic [7:0] idx);
        int cyc = 0;
        while (!(out_valid && out_index == idx) && cyc < 2000) begin
            out_ready = 1'b1;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("run_to_reached", 32'(out_valid && out_index == idx), 32'd1);
    endtask

    initial begin
        int exp_idx, hold_cnt, stall_cnt, cyc, dones;
        bit last_acc;

        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        rst_n = 1'b0; start = 0; abort = 0; mem_write = 0; out_ready = 0; file_id = 0;

        // reset state
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_index", 32'(out_index), 0);
        chk("rst_fid", 32'(out_file_id), 0);
        chk("rst_last", 32'(out_last), 0);
        @(negedge clk); rst_n = 1'b1;

        //            st fid  ab mw rdy  vld idx dat addr bsy dn ofid
        tbl[0] = '{1, 5'd5, 0, 0, 0,   0, 0, 0, 0,  1, 0, 5};  // start accepted
        tbl[1] = '{0, 5'd0, 0, 1, 0,   0, 0, 0, 0,  1, 0, 5};  // write stall in READ
        tbl[2] = '{0, 5'd0, 0, 0, 0,   1, 0, 0, 0,  1, 0, 5};  // first beat
        tbl[3] = '{0, 5'd0, 0, 0, 0,   1, 0, 0, 0,  1, 0, 5};  // held, no ready
        tbl[4] = '{0, 5'd0, 0, 0, 1,   0, 0, 0, 1,  1, 0, 5};  // accepted
        tbl[5] = '{0, 5'd0, 0, 0, 1,   1, 1, 3, 1,  1, 0, 5};  // beat 1
        tbl[6] = '{1, 5'd9, 0, 0, 1,   0, 0, 0, 2,  1, 0, 5};  // start ignored
        tbl[7] = '{0, 5'd0, 0, 0, 0,   1, 2, 6, 2,  1, 0, 5};  // beat 2
        tbl[8] = '{0, 5'd0, 1, 0, 1,   0, 0, 0, 0,  0, 0, 5};  // abort beats ready
        tbl[9] = '{0, 5'd0, 1, 0, 0,   0, 0, 0, 0,  0, 0, 5};  // abort in IDLE
        for (int i = 0; i < 10; i++) begin
            start = tbl[i].st; file_id = tbl[i].fid; abort = tbl[i].ab;
            mem_write = tbl[i].mw; out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("v%0d_fid", i), 32'(out_file_id), 32'(tbl[i].ofid));
            chk($sformatf("v%0d_last", i), 32'(out_last), 0);
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_index", i), 32'(out_index), 32'(tbl[i].idx));
                chk($sformatf("v%0d_data", i), 32'(out_data), 32'(tbl[i].dat));
            end
        end
        start = 0; abort = 0; mem_write = 0; out_ready = 0;

        // full dump, 4-cycle hold at index 10, 3-cycle write stall at addr 20
        @(negedge clk);
        start = 1; file_id = 5'd5;
        @(negedge clk);
        start = 0;
        exp_idx = 0; hold_cnt = 0; stall_cnt = 0; cyc = 0; dones = 0; last_acc = 0;
        while (!last_acc && cyc < 3000) begin
            if (done) dones++;
            mem_write = busy && !out_valid && mem_addr == 8'd20 && stall_cnt < 3;
            if (mem_write) stall_cnt++;
            out_ready = 1'b1;
            if (out_valid && out_index == 8'd10 && hold_cnt < 4) begin
                out_ready = 1'b0;
                hold_cnt++;
                chk("hold_data", 32'(out_data), 32'd30);
            end
            if (out_valid && out_ready) begin
                chk("beat_index", 32'(out_index), 32'(exp_idx));
                chk("beat_data", 32'(out_data), 32'(exp_idx * 3));
                chk("beat_fid", 32'(out_file_id), 32'd5);
                chk("beat_last", 32'(out_last), 32'(exp_idx == 255));
                exp_idx++;
                if (exp_idx == 256) last_acc = 1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 0; mem_write = 0;
        chk("dump_complete", 32'(last_acc), 1);
        chk("dump_beats", 32'(exp_idx), 256);
        chk("hold_cycles", 32'(hold_cnt), 4);
        chk("stall_cycles", 32'(stall_cnt), 3);
        chk("early_done", 32'(dones), 0);
        chk("done_pulse", 32'(done), 1);
        chk("done_addr_last", 32'(mem_addr), 255);
        @(negedge clk);
        chk("done_cleared", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_addr", 32'(mem_addr), 0);

        // abort while holding index 100, then a fresh dump starts at 0
        start = 1; file_id = 5'd3;
        @(negedge clk);
        start = 0;
        run_to(8'd100);
        abort = 1; out_ready = 1;
        @(negedge clk);
        abort = 0; out_ready = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(dones), 0);
        start = 1; file_id = 5'd3;
        @(negedge clk);
        start = 0;
        chk("restart_lat1", 32'(out_valid), 0);
        @(negedge clk);
        chk("restart_lat2", 32'(out_valid), 1);
        chk("restart_index", 32'(out_index), 0);
        chk("restart_data", 32'(out_data), 0);

        // start during a dump is ignored; async reset mid-dump
        run_to(8'd50);
        start = 1; file_id = 5'd7; out_ready = 1;
        @(negedge clk);
        start = 0; out_ready = 0;
        chk("restart_ignored_fid", 32'(out_file_id), 3);
        run_to(8'd51);
        chk("after_ignored_data", 32'(out_data), 153);
        run_to(8'd60);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_index", 32'(out_index), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_fid", 32'(out_file_id), 0);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("post_rst_idle", 32'(dones), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
